// File: rtl/manufacturing_pkg.sv
// Shared state encodings and ESTOP fault codes for the manufacturing line controller.
package manufacturing_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_NORMAL   = 3'd1,
        ST_HANDLING = 3'd2,
        ST_RETURN   = 3'd3,
        ST_COOLING  = 3'd4,
        ST_ESTOP    = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        FC_NONE           = 3'd0,
        FC_EMERGENCY      = 3'd1,
        FC_OVERCURRENT    = 3'd2,
        FC_HANDLER_ERROR  = 3'd3,
        FC_HANDLE_TIMEOUT = 3'd4
    } fault_t;

endpackage

// File: rtl/prio_onehot.sv
// Lowest-index-first one-hot selector; picks which reject station gets serviced.
module prio_onehot #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    output logic [N-1:0] grant
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        grant = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/manufacturing_line_ctrl.sv
// Conveyor line supervisor: multi-station reject handling, cooling dwell, sticky fault code
// and edge-qualified restart out of emergency stop.
//
// state    | meaning
// IDLE     | after reset or restart, waiting to start the line
// NORMAL   | conveyor running, watching detectors
// HANDLING | servicing pending reject stations, lowest index first
// RETURN   | all rejects done, waiting for line ready
// COOLING  | fan on, minimum dwell before resuming
// ESTOP    | stopped with latched fault code, wait for restart press
module manufacturing_line_ctrl
    import manufacturing_pkg::*;
#(
    parameter int N_ST       = 4,
    parameter int TMO_W      = 16,
    parameter int HANDLE_TMO = 1000,
    parameter int COOL_MIN   = 500,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_ST-1:0]  metal_detected,
    input  logic [N_ST-1:0]  done,
    input  logic             high_temp,
    input  logic             temp_normal,
    input  logic             overcurrent,
    input  logic             error,
    input  logic             ready,
    input  logic             emergency,
    input  logic             reset_btn,
    output logic             conveyor,
    output logic [N_ST-1:0]  servo,
    output logic             fan,
    output logic             warning_light,
    output logic             buzzer,
    output logic             valve,
    output logic [2:0]       state,
    output logic [2:0]       fault_code,
    output logic [CNT_W-1:0] reject_count
);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(HANDLE_TMO - 1);
    localparam logic [TMO_W-1:0] COOL_THR = TMO_W'(COOL_MIN);

    state_t            state_q, state_d;
    fault_t            fault_q, fault_d;
    logic [N_ST-1:0]   pending_q, pending_d;
    logic [TMO_W-1:0]  dwell_q, dwell_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              rbtn_q;

    logic [N_ST-1:0]   sel;
    logic [N_ST-1:0]   pend_next;
    logic              svc_done;
    logic              estop_go;
    fault_t            estop_code;

    prio_onehot #(.N(N_ST)) u_prio (
        .req   (pending_q),
        .grant (sel)
    );

    assign svc_done  = |(done & sel);
    assign pend_next = (pending_q & ~(svc_done ? sel : '0)) | metal_detected;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            fault_q   <= FC_NONE;
            pending_q <= '0;
            dwell_q   <= '0;
            count_q   <= '0;
            rbtn_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            fault_q   <= fault_d;
            pending_q <= pending_d;
            dwell_q   <= dwell_d;
            count_q   <= count_d;
            rbtn_q    <= reset_btn;
        end
    end

    always_comb begin
        state_d    = state_q;
        fault_d    = fault_q;
        pending_d  = pending_q;
        dwell_d    = dwell_q;
        count_d    = count_q;
        estop_go   = 1'b0;
        estop_code = FC_NONE;

        case (state_q)
            ST_IDLE: begin
                if (emergency) begin
                    estop_go   = 1'b1;
                    estop_code = FC_EMERGENCY;
                end else begin
                    state_d = ST_NORMAL;
                end
            end
            ST_NORMAL: begin
                if (emergency) begin
                    estop_go   = 1'b1;
                    estop_code = FC_EMERGENCY;
                end else if (overcurrent) begin
                    estop_go   = 1'b1;
                    estop_code = FC_OVERCURRENT;
                end else if (|metal_detected) begin
                    pending_d = pending_q | metal_detected;
                    dwell_d   = '0;
                    state_d   = ST_HANDLING;
                end else if (high_temp) begin
                    dwell_d = '0;
                    state_d = ST_COOLING;
                end
            end
            ST_HANDLING: begin
                pending_d = pend_next;
                dwell_d   = svc_done ? '0 : dwell_q + TMO_W'(1);
                // A completed reject is counted even if a fault stops the line that cycle.
                if (svc_done && (count_q != '1)) count_d = count_q + CNT_W'(1);
                if (emergency) begin
                    estop_go   = 1'b1;
                    estop_code = FC_EMERGENCY;
                end else if (overcurrent) begin
                    estop_go   = 1'b1;
                    estop_code = FC_OVERCURRENT;
                end else if (error) begin
                    estop_go   = 1'b1;
                    estop_code = FC_HANDLER_ERROR;
                end else if (!svc_done && (dwell_q >= TMO_LAST)) begin
                    estop_go   = 1'b1;
                    estop_code = FC_HANDLE_TIMEOUT;
                end else if (pend_next == '0) begin
                    state_d = ST_RETURN;
                end
            end
            ST_RETURN: begin
                if (emergency) begin
                    estop_go   = 1'b1;
                    estop_code = FC_EMERGENCY;
                end else if (overcurrent) begin
                    estop_go   = 1'b1;
                    estop_code = FC_OVERCURRENT;
                end else if (high_temp) begin
                    dwell_d = '0;
                    state_d = ST_COOLING;
                end else if (ready) begin
                    state_d = ST_NORMAL;
                end
            end
            ST_COOLING: begin
                if (dwell_q != '1) dwell_d = dwell_q + TMO_W'(1);
                if (emergency) begin
                    estop_go   = 1'b1;
                    estop_code = FC_EMERGENCY;
                end else if (overcurrent) begin
                    estop_go   = 1'b1;
                    estop_code = FC_OVERCURRENT;
                end else if (temp_normal && (dwell_q >= COOL_THR)) begin
                    state_d = ST_NORMAL;
                end
            end
            ST_ESTOP: begin
                if (reset_btn && !rbtn_q && !emergency) begin
                    state_d = ST_IDLE;
                    fault_d = FC_NONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (estop_go) begin
            state_d   = ST_ESTOP;
            fault_d   = estop_code;
            pending_d = '0;
            dwell_d   = '0;
        end
    end

    always_comb begin
        conveyor      = 1'b0;
        servo         = '0;
        fan           = 1'b0;
        warning_light = 1'b0;
        buzzer        = 1'b0;
        valve         = 1'b0;
        case (state_q)
            ST_NORMAL: begin
                conveyor = 1'b1;
                valve    = ~high_temp;
            end
            ST_HANDLING: begin
                conveyor = 1'b1;
                servo    = sel;
            end
            ST_RETURN: conveyor = 1'b1;
            ST_COOLING: begin
                fan           = 1'b1;
                warning_light = 1'b1;
                buzzer        = 1'b1;
            end
            ST_ESTOP: begin
                warning_light = 1'b1;
                buzzer        = 1'b1;
            end
            default: ;
        endcase
    end

    assign state        = state_q;
    assign fault_code   = fault_q;
    assign reject_count = count_q;

endmodule

// File: tb/tb_manufacturing_line_ctrl.sv
// Self-checking bench for manufacturing_line_ctrl: a queue holds the expected servo
// service order, pushed when metal is driven and popped as each station is serviced.
module tb_manufacturing_line_ctrl;

    localparam int N_ST    = 4;
    localparam int CNT_W   = 3;
    localparam int CNT_MAX = 7;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N_ST-1:0]  metal_detected = '0;
    logic [N_ST-1:0]  done = '0;
    logic             high_temp = 1'b0;
    logic             temp_normal = 1'b0;
    logic             overcurrent = 1'b0;
    logic             error = 1'b0;
    logic             ready = 1'b0;
    logic             emergency = 1'b0;
    logic             reset_btn = 1'b0;
    logic             conveyor;
    logic [N_ST-1:0]  servo;
    logic             fan;
    logic             warning_light;
    logic             buzzer;
    logic             valve;
    logic [2:0]       state;
    logic [2:0]       fault_code;
    logic [CNT_W-1:0] reject_count;

    logic [N_ST-1:0] exp_q[$];
    int exp_count = 0;
    int tests = 0;
    int fails = 0;

    manufacturing_line_ctrl #(
        .N_ST       (N_ST),
        .TMO_W      (8),
        .HANDLE_TMO (10),
        .COOL_MIN   (20),
        .CNT_W      (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .metal_detected (metal_detected),
        .done           (done),
        .high_temp      (high_temp),
        .temp_normal    (temp_normal),
        .overcurrent    (overcurrent),
        .error          (error),
        .ready          (ready),
        .emergency      (emergency),
        .reset_btn      (reset_btn),
        .conveyor       (conveyor),
        .servo          (servo),
        .fan            (fan),
        .warning_light  (warning_light),
        .buzzer         (buzzer),
        .valve          (valve),
        .state          (state),
        .fault_code     (fault_code),
        .reject_count   (reject_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_metal(input logic [N_ST-1:0] m);
        logic [N_ST-1:0] oh;
        for (int i = 0; i < N_ST; i++) begin
            if (m[i]) begin
                oh = '0;
                oh[i] = 1'b1;
                exp_q.push_back(oh);
            end
        end
    endtask

    task automatic bump_count();
        if (exp_count < CNT_MAX) exp_count++;
    endtask

    task automatic service_all();
        logic [N_ST-1:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (state !== 3'd2 || servo !== e) begin
                fails++;
                $display("FAIL service: state %0d servo %b, want state 2 servo %b", state, servo, e);
            end
            done = e;
            tick();
            done = '0;
            bump_count();
        end
    endtask

    task automatic restart();
        reset_btn = 1'b1;
        tick();
        reset_btn = 1'b0;
        tests++;
        if (state !== 3'd0 || fault_code !== 3'd0) begin
            fails++;
            $display("FAIL restart_idle: state %0d code %0d, want 0 0", state, fault_code);
        end
        tick();
        tests++;
        if (state !== 3'd1) begin
            fails++;
            $display("FAIL restart_normal: state %0d, want 1", state);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (state !== 3'd0 || fault_code !== 3'd0 || reject_count !== 3'd0) begin
            fails++;
            $display("FAIL reset_regs: state %0d code %0d count %0d, want 0 0 0", state, fault_code, reject_count);
        end
        tests++;
        if ({conveyor, servo, fan, warning_light, buzzer, valve} !== 9'd0) begin
            fails++;
            $display("FAIL reset_outputs: %b, want all 0", {conveyor, servo, fan, warning_light, buzzer, valve});
        end
        rst = 1'b0;
        tick();
        tests++;
        if (state !== 3'd1 || conveyor !== 1'b1 || valve !== 1'b1) begin
            fails++;
            $display("FAIL first_normal: state %0d conv %b valve %b, want 1 1 1", state, conveyor, valve);
        end
    endtask

    task automatic test_cooling();
        int n;
        high_temp = 1'b1;
        #1;
        tests++;
        if (state !== 3'd1 || valve !== 1'b0) begin
            fails++;
            $display("FAIL valve_drop: state %0d valve %b, want 1 0", state, valve);
        end
        tick();
        high_temp = 1'b0;
        tests++;
        if (state !== 3'd4 || fan !== 1'b1 || warning_light !== 1'b1 || buzzer !== 1'b1 || conveyor !== 1'b0) begin
            fails++;
            $display("FAIL cool_entry: state %0d fan %b, want 4 1", state, fan);
        end
        n = 0;
        while (state === 3'd4 && n < 100) begin
            if (n == 3) temp_normal = 1'b1;
            tick();
            n++;
        end
        temp_normal = 1'b0;
        tests++;
        if (n != 21 || state !== 3'd1) begin
            fails++;
            $display("FAIL cool_dwell: %0d cycles then state %0d, want 21 then 1", n, state);
        end
    endtask

    task automatic test_handling();
        metal_detected = 4'b1010;
        push_metal(4'b1010);
        tick();
        metal_detected = '0;
        done = 4'b1000;
        tick();
        done = '0;
        tests++;
        if (servo !== 4'b0010 || reject_count !== 3'(exp_count)) begin
            fails++;
            $display("FAIL ignore_done: servo %b count %0d, want 0010 %0d", servo, reject_count, exp_count);
        end
        service_all();
        tests++;
        if (state !== 3'd3 || reject_count !== 3'(exp_count)) begin
            fails++;
            $display("FAIL handling_done: state %0d count %0d, want 3 %0d", state, reject_count, exp_count);
        end
        ready = 1'b1;
        tick();
        ready = 1'b0;
        tests++;
        if (state !== 3'd1) begin
            fails++;
            $display("FAIL return_ready: state %0d, want 1", state);
        end
    endtask

    task automatic test_back_to_back();
        logic [N_ST-1:0] e;
        metal_detected = 4'b0100;
        push_metal(4'b0100);
        tick();
        metal_detected = '0;
        e = exp_q.pop_front();
        tests++;
        if (servo !== e) begin
            fails++;
            $display("FAIL b2b_first: servo %b, want %b", servo, e);
        end
        done = e;
        metal_detected = 4'b0001;
        push_metal(4'b0001);
        tick();
        done = '0;
        metal_detected = '0;
        bump_count();
        tests++;
        if (state !== 3'd2) begin
            fails++;
            $display("FAIL b2b_stay: state %0d, want 2", state);
        end
        service_all();
        tests++;
        if (state !== 3'd3 || reject_count !== 3'(exp_count)) begin
            fails++;
            $display("FAIL b2b_done: state %0d count %0d, want 3 %0d", state, reject_count, exp_count);
        end
        ready = 1'b1;
        tick();
        ready = 1'b0;
    endtask

    task automatic test_timeout();
        int n;
        metal_detected = 4'b0001;
        tick();
        metal_detected = '0;
        n = 0;
        while (state === 3'd2 && n < 50) begin
            tick();
            n++;
        end
        tests++;
        if (n != 10 || state !== 3'd5 || fault_code !== 3'd4) begin
            fails++;
            $display("FAIL timeout: %0d cycles state %0d code %0d, want 10 5 4", n, state, fault_code);
        end
        tests++;
        if (servo !== 4'b0000 || conveyor !== 1'b0 || warning_light !== 1'b1 || buzzer !== 1'b1) begin
            fails++;
            $display("FAIL estop_outputs: servo %b conv %b warn %b buzz %b, want 0000 0 1 1",
                     servo, conveyor, warning_light, buzzer);
        end
        restart();
    endtask

    task automatic test_estop_restart();
        metal_detected = 4'b0010;
        push_metal(4'b0010);
        tick();
        metal_detected = '0;
        service_all();
        emergency = 1'b1;
        tick();
        tests++;
        if (state !== 3'd5 || fault_code !== 3'd1) begin
            fails++;
            $display("FAIL estop_emerg: state %0d code %0d, want 5 1", state, fault_code);
        end
        reset_btn = 1'b1;
        repeat (2) tick();
        tests++;
        if (state !== 3'd5) begin
            fails++;
            $display("FAIL hold_emerg: state %0d, want 5", state);
        end
        emergency = 1'b0;
        repeat (2) tick();
        tests++;
        if (state !== 3'd5 || fault_code !== 3'd1) begin
            fails++;
            $display("FAIL held_btn: state %0d code %0d, want 5 1", state, fault_code);
        end
        reset_btn = 1'b0;
        tick();
        restart();
    endtask

    task automatic test_fault_priority();
        overcurrent = 1'b1;
        emergency = 1'b1;
        tick();
        overcurrent = 1'b0;
        emergency = 1'b0;
        tests++;
        if (state !== 3'd5 || fault_code !== 3'd1) begin
            fails++;
            $display("FAIL emerg_over_oc: state %0d code %0d, want 5 1", state, fault_code);
        end
        restart();
        overcurrent = 1'b1;
        tick();
        overcurrent = 1'b0;
        tests++;
        if (fault_code !== 3'd2) begin
            fails++;
            $display("FAIL overcurrent: code %0d, want 2", fault_code);
        end
        restart();
        metal_detected = 4'b0001;
        tick();
        metal_detected = '0;
        error = 1'b1;
        tick();
        error = 1'b0;
        tests++;
        if (state !== 3'd5 || fault_code !== 3'd3) begin
            fails++;
            $display("FAIL handler_error: state %0d code %0d, want 5 3", state, fault_code);
        end
        restart();
    endtask

    task automatic test_saturation();
        metal_detected = 4'b1111;
        push_metal(4'b1111);
        tick();
        metal_detected = '0;
        service_all();
        tests++;
        if (reject_count !== 3'(exp_count) || exp_count != CNT_MAX) begin
            fails++;
            $display("FAIL saturate: count %0d model %0d, want %0d", reject_count, exp_count, CNT_MAX);
        end
        ready = 1'b1;
        tick();
        ready = 1'b0;
    endtask

    task automatic test_reset_midop();
        metal_detected = 4'b0001;
        tick();
        metal_detected = '0;
        rst = 1'b1;
        #1;
        tests++;
        if (state !== 3'd0 || reject_count !== 3'd0 || servo !== 4'b0000 || conveyor !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: state %0d count %0d servo %b, want 0 0 0000", state, reject_count, servo);
        end
        tick();
        rst = 1'b0;
        tick();
        tests++;
        if (state !== 3'd1) begin
            fails++;
            $display("FAIL post_reset: state %0d, want 1", state);
        end
    endtask

    initial begin
        test_reset();
        test_cooling();
        test_handling();
        test_back_to_back();
        test_timeout();
        test_estop_restart();
        test_fault_priority();
        test_saturation();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/manufacturing_line_ctrl.md
Name: manufacturing_line_ctrl

Overview:
Parametrised successor to the single-station manufacturing FSM. Supervises a conveyor line with N_ST metal-reject stations, each with its own servo and done handshake. Adds handling timeout, minimum cooling dwell, a sticky fault code, edge-qualified restart and a saturating reject counter. Sits between the line sensor/actuator I/O and the plant supervisor.

Parameters:
N_ST, 4, number of reject stations (1..16)
TMO_W, 16, width of dwell/timeout counter
HANDLE_TMO, 1000, max cycles a station may stay serviced without done (1..2^TMO_W-1)
COOL_MIN, 500, minimum cycles in COOLING before exit (0..2^TMO_W-1)
CNT_W, 16, width of reject counter

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
metal_detected  in  N_ST  per-station metal detect, level
done  in  N_ST  per-station reject-complete strobe
high_temp  in  1  over-temperature
temp_normal  in  1  temperature back in range
overcurrent  in  1  motor overcurrent
error  in  1  reject handler error
ready  in  1  line ready to resume
emergency  in  1  emergency stop request, level
reset_btn  in  1  operator restart
conveyor  out  1  conveyor drive
servo  out  N_ST  one-hot reject servo drive
fan  out  1  cooling fan
warning_light  out  1  warning lamp
buzzer  out  1  buzzer
valve  out  1  coolant valve
state  out  3  current state encoding
fault_code  out  3  sticky cause of last ESTOP
reject_count  out  CNT_W  saturating count of completed rejects

Behaviour:
- Reset: state=IDLE; pending mask, counters, fault_code, reject_count, reset_btn history = 0; all actuator outputs 0.
- States: IDLE=0, NORMAL=1, HANDLING=2, RETURN=3, COOLING=4, ESTOP=5. Encodings 6, 7 go to IDLE next cycle.
- Priority in every state except ESTOP: emergency > overcurrent > error (HANDLING only) > timeout > metal > high_temp.
- IDLE: emergency -> ESTOP (code 1), else -> NORMAL.
- NORMAL: overcurrent -> ESTOP (code 2). If any metal_detected bit is set, pending |= metal_detected and go to HANDLING. Else high_temp -> COOLING.
- HANDLING:
  - Every cycle, pending |= metal_detected.
  - Serviced station = lowest-index set bit of pending; servo is one-hot on that bit.
  - done on the serviced bit clears that bit, increments reject_count (saturates at all-ones) and zeroes the dwell counter. done on non-serviced bits is ignored.
  - Dwell counter increments each cycle without a serviced done. Reaching HANDLE_TMO -> ESTOP (code 4).
  - error -> ESTOP (code 3).
  - When pending becomes 0 after a done, with no new metal that cycle -> RETURN. Metal in the same cycle keeps HANDLING.
  - high_temp does not preempt HANDLING.
- RETURN: high_temp -> COOLING, else ready -> NORMAL.
- COOLING:
  - Dwell counter counts from 0 on entry.
  - Exit to NORMAL needs temp_normal=1 and counter>=COOL_MIN. Counter saturates.
- ESTOP:
  - fault_code is latched on entry only.
  - Exits to IDLE on a rising edge of reset_btn (registered previous value) while emergency=0.
  - A held reset_btn does not retrigger. Exit clears fault_code to 0.
  - pending is cleared on entry to ESTOP.
- Outputs are Moore decodes of state:
  - NORMAL: conveyor=1, valve=~high_temp.
  - HANDLING: conveyor=1, servo as above.
  - RETURN: conveyor=1.
  - COOLING: fan, warning_light, buzzer = 1.
  - ESTOP: warning_light, buzzer = 1.
  - All others 0. state output = state register.
- Reset mid-operation returns to IDLE immediately. reject_count is cleared only by rst.

Decomposition:
- Package manufacturing_pkg holds: state encodings, fault codes (NONE=0, EMERGENCY=1, OVERCURRENT=2, HANDLER_ERROR=3, HANDLE_TIMEOUT=4).
- One sub-module: prio_onehot (N_ST-wide lowest-set-bit one-hot selector) used for servo selection.

Test Plan:
- Reset, metal=0 -> NORMAL at cycle 1. conveyor=1, valve=1. With high_temp=1: valve drops, next cycle COOLING.
- metal_detected=4'b1010 in NORMAL -> servo=4'b0010. done=4'b0010 -> servo=4'b1000. done=4'b1000 -> RETURN, reject_count=2.
- HANDLE_TMO=10, no done -> ESTOP exactly 10 cycles after HANDLING entry, fault_code=4.
- COOL_MIN=20, temp_normal=1 on cycle 3 of COOLING -> stays until cycle 20, then NORMAL.
- emergency=1 in RETURN -> ESTOP, code 1. reset_btn held high with emergency=1 stays ESTOP. Emergency dropped while reset_btn still high stays ESTOP. Release and re-press -> IDLE, fault_code=0.
- overcurrent and emergency asserted together in NORMAL -> fault_code=1. reject_count at all-ones plus done -> holds all-ones.
